// File: rtl/mod_op_sequencer_if.sv
// Handshake bundle between requester, sequencer,
// serial add/sub core and response consumer.
interface mod_op_sequencer_if;
  logic       cmd_valid;
  logic       cmd_op;
  logic       cmd_ready;
  logic       madd_en;
  logic       msub_en;
  logic       count_en;
  logic [3:0] count;
  logic       result_rdy;
  logic       result_flag;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_flag;
  logic       rsp_err;
  logic       busy;

  modport slave (
    input  cmd_valid, cmd_op, count_en,
    input  result_rdy, result_flag, rsp_ready,
    output cmd_ready, madd_en, msub_en, count,
    output rsp_valid, rsp_flag, rsp_err, busy
  );

  modport master (
    output cmd_valid, cmd_op, count_en,
    output result_rdy, result_flag, rsp_ready,
    input  cmd_ready, madd_en, msub_en, count,
    input  rsp_valid, rsp_flag, rsp_err, busy
  );
endinterface

// File: rtl/mod_op_sequencer.sv
// Sequences one modular add/sub through a serial core:
// issue a start pulse, wait for done or timeout, respond.
module mod_op_sequencer #(
  parameter int TIMEOUT = 40
) (
  input logic clk,
  input logic rst,
  mod_op_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [5:0] LP_LAST = 6'(TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next;
  logic       r_op;
  logic [3:0] r_count;
  logic [5:0] r_wcnt;
  logic       r_flag;
  logic       r_err;
  logic       w_accept;
  logic       w_cap;
  logic       w_expire;

  assign w_accept = (r_state == S_IDLE) & bus.cmd_valid;
  assign w_expire = (r_wcnt == LP_LAST);

  always_comb begin
    w_next = r_state;
    w_cap  = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.cmd_valid) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (bus.result_rdy | w_expire) begin
          w_next = S_RESP;
          w_cap  = 1'b1;
        end
      end
      S_RESP:  if (bus.rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= 1'b0;
      r_count <= 4'd0;
      r_wcnt  <= 6'd0;
      r_flag  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_op <= bus.cmd_op;
      // Start of a new op restarts digit indexing.
      if (r_state == S_ISSUE)
        r_count <= 4'd0;
      else if (bus.count_en)
        r_count <= r_count + 4'd1;
      if (r_state == S_ISSUE)
        r_wcnt <= 6'd0;
      else if (r_state == S_WAIT)
        r_wcnt <= r_wcnt + 6'd1;
      // Done on the expiry cycle still counts as success.
      if (w_cap) begin
        r_flag <= bus.result_rdy & bus.result_flag;
        r_err  <= ~bus.result_rdy;
      end
    end
  end

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.madd_en   = (r_state == S_ISSUE) & ~r_op;
  assign bus.msub_en   = (r_state == S_ISSUE) & r_op;
  assign bus.count     = r_count;
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_flag  = r_flag;
  assign bus.rsp_err   = r_err;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mod_op_sequencer.sv
// Randomized self-checking bench for mod_op_sequencer
// with a cycle-level reference of the op timeline.
module tb_mod_op_sequencer;

  localparam int TO = 40;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  mod_op_sequencer_if bus ();

  mod_op_sequencer #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: WAIT spans cycles 2..TO+1; done seen there wins.
  function automatic int exp_cyc(input int done);
    if (done >= 2 && done <= TO + 1) return done + 1;
    return TO + 2;
  endfunction

  function automatic bit exp_err(input int done);
    return !(done >= 2 && done <= TO + 1);
  endfunction

  task automatic idle_inputs();
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = 1'b0;
    bus.count_en    = 1'b0;
    bus.result_rdy  = 1'b0;
    bus.result_flag = 1'b0;
    bus.rsp_ready   = 1'b0;
  endtask

  // Drives one op from acceptance (cycle 0) to rsp handshake.
  task automatic run_op(
    input  bit op, input int done, input bit flag,
    input  int hold, input bit stale, input bit rnd_en,
    output int acc, output int rcyc, output bit rflag,
    output bit rerr, output int pulses, output int bad);
    int strobes;
    int first;
    bit hs;
    int lim;
    strobes = 0; first = -1; hs = 0;
    acc = 0; pulses = 0; bad = 0; rflag = 0; rerr = 0;
    lim = (done < 0) ? 34 : done;
    for (int c = 0; c < 90 && !hs; c++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op = (c == 0) ? op : 1'($urandom_range(1));
      if (rnd_en)
        bus.count_en = (c >= 1) ? 1'($urandom_range(1)) : 1'b0;
      else
        bus.count_en = (c >= 2 && c < lim);
      bus.result_rdy = (stale && c < 2) || (done >= 2 && c >= done);
      bus.result_flag = (stale && c < 2) ? !flag : flag;
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      if (c == 0) acc = int'(bus.cmd_ready);
      else if (bus.cmd_ready) bad++;
      if (bus.busy !== (c > 0)) bad++;
      if (bus.madd_en) begin
        if (!op && c == 1) pulses++; else bad++;
      end
      if (bus.msub_en) begin
        if (op && c == 1) pulses++; else bad++;
      end
      if (c >= 2 && bus.count !== 4'(strobes % 16)) bad++;
      if (c >= 2 && bus.count_en) strobes++;
      if (bus.rsp_valid) begin
        if (first < 0) begin
          first = c; rflag = bus.rsp_flag; rerr = bus.rsp_err;
        end else if (bus.rsp_flag !== rflag ||
                     bus.rsp_err !== rerr) begin
          bad++;
        end
        if (c - first >= hold) begin
          bus.rsp_ready = 1'b1;
          hs = 1;
        end
      end else if (first >= 0) begin
        bad++;
      end
      @(posedge clk);
      #1;
    end
    idle_inputs();
    rcyc = hs ? first : -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #12;
    n_cmp += 4;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy_rsp got %b%b exp 00",
               bus.busy, bus.rsp_valid);
    end
    if (bus.count !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_count got %0d exp 0", bus.count);
    end
    if (bus.madd_en !== 1'b0 || bus.msub_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_en got %b%b exp 00",
               bus.madd_en, bus.msub_en);
    end
    if (bus.rsp_flag !== 1'b0 || bus.rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_rsp got %b%b exp 00",
               bus.rsp_flag, bus.rsp_err);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ready got %b exp 1", bus.cmd_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_scenario(
    input string nm, input bit op, input int done,
    input bit flag, input int hold, input bit stale,
    input bit rnd_en);
    int acc, rcyc, pulses, bad;
    bit rflag, rerr;
    int ec;
    bit ee, ef;
    run_op(op, done, flag, hold, stale, rnd_en,
           acc, rcyc, rflag, rerr, pulses, bad);
    ec = exp_cyc(done);
    ee = exp_err(done);
    ef = ee ? 1'b0 : flag;
    n_cmp += 6;
    if (acc !== 1) begin
      n_fail++;
      $display("FAIL %s accept got %0d exp 1", nm, acc);
    end
    if (rcyc !== ec) begin
      n_fail++;
      $display("FAIL %s rsp_cycle got %0d exp %0d", nm, rcyc, ec);
    end
    if (rflag !== ef) begin
      n_fail++;
      $display("FAIL %s rsp_flag got %b exp %b", nm, rflag, ef);
    end
    if (rerr !== ee) begin
      n_fail++;
      $display("FAIL %s rsp_err got %b exp %b", nm, rerr, ee);
    end
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL %s en_pulse got %0d exp 1", nm, pulses);
    end
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL %s cycle_errs got %0d exp 0", nm, bad);
    end
  endtask

  task automatic test_add();
    test_scenario("add", 1'b0, 34, 1'b1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_sub();
    test_scenario("sub", 1'b1, 18, 1'b0, 0, 1'b0, 1'b0);
    test_scenario("sub_wrap", 1'b1, 34, 1'b1, 1, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    test_scenario("timeout", 1'b0, -1, 1'b1, 0, 1'b0, 1'b0);
    test_scenario("add_after_to", 1'b0, 34, 1'b1, 0, 1'b0, 1'b0);
    test_scenario("done_at_expiry", 1'b1, TO + 1, 1'b1, 0,
                  1'b0, 1'b0);
    test_scenario("done_after_expiry", 1'b0, TO + 2, 1'b1, 0,
                  1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    test_scenario("hold", 1'b1, 18, 1'b1, 10, 1'b0, 1'b0);
    test_scenario("b2b", 1'b0, 34, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_stale();
    test_scenario("stale", 1'b0, 25, 1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 1'b0;
    for (int c = 0; c < 20; c++) begin
      bus.count_en = (c >= 2);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
    end
    bus.count_en = 1'b0;
    rst = 1'b1;
    #2;
    n_cmp += 3;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_busy got %b exp 0", bus.busy);
    end
    if (bus.count !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_rst_count got %0d exp 0", bus.count);
    end
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_rsp got %b exp 0", bus.rsp_valid);
    end
    #1;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_rst_quiet got %b%b exp 00",
                 bus.rsp_valid, bus.busy);
      end
    end
    @(posedge clk);
    #1;
    test_scenario("sub_after_rst", 1'b1, 18, 1'b0, 0,
                  1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      test_scenario("rand", 1'($urandom_range(1)),
                    int'($urandom_range(46, 2)),
                    1'($urandom_range(1)),
                    int'($urandom_range(3)),
                    1'($urandom_range(1)), 1'b1);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_add();
    test_sub();
    test_timeout();
    test_back_to_back();
    test_stale();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
